// File: rtl/param_loader_pkg.sv
// Shared encodings for the parameter loader: request types, field sizes and FSM states.
package param_loader_pkg;

  typedef enum logic [1:0] {
    ReqKey   = 2'd0,
    ReqNonce = 2'd1,
    ReqCtr   = 2'd2
  } req_type_e;

  localparam int unsigned KeyWords   = 8;
  localparam int unsigned NonceWords = 3;
  localparam int unsigned CtrWords   = 1;

  typedef enum logic [2:0] {
    StIdle,
    StKey,
    StNonce,
    StCtr,
    StFinish,
    StAbort
  } state_e;

  function automatic logic [4:0] last_index(req_type_e t);
    case (t)
      ReqKey:   return 5'(KeyWords - 1);
      ReqNonce: return 5'(NonceWords - 1);
      default:  return 5'(CtrWords - 1);
    endcase
  endfunction

endpackage

// File: rtl/param_word_fetch.sv
// Single-word fetch from the chunk interface, the TRNG, or a zero fill, with a
// per-word wait counter that flags a timeout when no word arrives in time.
module param_word_fetch
  import param_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        streamed,
  input  logic        zero_fill,
  input  req_type_e   req_type,
  input  logic        chunk_valid,
  input  logic [1:0]  chunk_type,
  input  logic [31:0] chunk,
  input  logic        trng_ready,
  input  logic [31:0] trng_data,
  output logic        capture,
  output logic [31:0] word,
  output logic        timeout
);

  logic [15:0] wait_q;
  logic [15:0] wait_d;

  always_comb begin
    capture = 1'b0;
    word    = 32'd0;
    if (active) begin
      if (streamed) begin
        // Chunks tagged with a different field are silently dropped.
        capture = chunk_valid && (chunk_type == req_type);
        word    = chunk;
      end else if (zero_fill) begin
        capture = 1'b1;
      end else begin
        capture = trng_ready;
        word    = trng_data;
      end
    end
  end

  assign timeout = active && !capture && (wait_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_d = wait_q + 16'd1;
    if (!active || capture || timeout) begin
      wait_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 16'd0;
    end else begin
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/param_loader.sv
// Loads key, nonce and counter word by word from a streamed chunk interface or from
// default sources (TRNG for key/nonce, zero for counter), with per-word timeout abort.
module param_loader
  import param_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         use_streamed_key,
  input  logic         use_streamed_nonce,
  input  logic         use_streamed_counter,
  input  logic [1:0]   chunk_type,
  input  logic         chunk_valid,
  input  logic [31:0]  chunk,
  output logic         chunk_request,
  output logic [1:0]   request_type,
  output logic [4:0]   chunk_index,
  input  logic [31:0]  trng_data,
  input  logic         trng_ready,
  output logic         trng_request,
  output logic [255:0] key_out,
  output logic [95:0]  nonce_out,
  output logic [31:0]  counter_out,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         params_valid
);

  state_e         state_q;
  req_type_e      rtype_q;
  logic [2:0]     sel_q;
  logic [4:0]     idx_q;
  logic           busy_q, done_q, error_q, pvalid_q, creq_q, treq_q;
  logic [255:0]   key_q;
  logic [95:0]    nonce_q;
  logic [31:0]    ctr_q;

  logic           active, cur_streamed, capture, timeout, last_word;
  logic [31:0]    word;

  assign active    = (state_q == StKey) || (state_q == StNonce) || (state_q == StCtr);
  assign last_word = (idx_q == last_index(rtype_q));

  always_comb begin
    cur_streamed = 1'b0;
    unique case (state_q)
      StKey:   cur_streamed = sel_q[0];
      StNonce: cur_streamed = sel_q[1];
      StCtr:   cur_streamed = sel_q[2];
      default: cur_streamed = 1'b0;
    endcase
  end

  param_word_fetch #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (active),
    .streamed   (cur_streamed),
    .zero_fill  (state_q == StCtr),
    .req_type   (rtype_q),
    .chunk_valid(chunk_valid),
    .chunk_type (chunk_type),
    .chunk      (chunk),
    .trng_ready (trng_ready),
    .trng_data  (trng_data),
    .capture    (capture),
    .word       (word),
    .timeout    (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rtype_q  <= ReqKey;
      sel_q    <= 3'b000;
      idx_q    <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      pvalid_q <= 1'b0;
      creq_q   <= 1'b0;
      treq_q   <= 1'b0;
      key_q    <= '0;
      nonce_q  <= '0;
      ctr_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sel_q    <= {use_streamed_counter, use_streamed_nonce, use_streamed_key};
            busy_q   <= 1'b1;
            pvalid_q <= 1'b0;
            idx_q    <= 5'd0;
            rtype_q  <= ReqKey;
            creq_q   <= use_streamed_key;
            treq_q   <= !use_streamed_key;
            state_q  <= StKey;
          end
        end
        StKey, StNonce, StCtr: begin
          if (timeout) begin
            creq_q  <= 1'b0;
            treq_q  <= 1'b0;
            rtype_q <= ReqKey;
            idx_q   <= 5'd0;
            error_q <= 1'b1;
            state_q <= StAbort;
          end else if (capture) begin
            if (state_q == StKey) begin
              for (int unsigned i = 0; i < KeyWords; i++) begin
                if (idx_q == 5'(i)) key_q[32*i +: 32] <= word;
              end
            end else if (state_q == StNonce) begin
              for (int unsigned i = 0; i < NonceWords; i++) begin
                if (idx_q == 5'(i)) nonce_q[32*i +: 32] <= word;
              end
            end else begin
              ctr_q <= word;
            end
            if (!last_word) begin
              idx_q <= idx_q + 5'd1;
            end else begin
              idx_q <= 5'd0;
              // Set up the next field's request on the same edge as the last capture.
              if (state_q == StKey) begin
                rtype_q <= ReqNonce;
                creq_q  <= sel_q[1];
                treq_q  <= !sel_q[1];
                state_q <= StNonce;
              end else if (state_q == StNonce) begin
                rtype_q <= ReqCtr;
                creq_q  <= sel_q[2];
                treq_q  <= 1'b0;
                state_q <= StCtr;
              end else begin
                rtype_q <= ReqKey;
                creq_q  <= 1'b0;
                treq_q  <= 1'b0;
                state_q <= StFinish;
              end
            end
          end
        end
        StFinish: begin
          done_q   <= 1'b1;
          pvalid_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        StAbort: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign chunk_request = creq_q;
  assign trng_request  = treq_q;
  assign request_type  = rtype_q;
  assign chunk_index   = idx_q;
  assign key_out       = key_q;
  assign nonce_out     = nonce_q;
  assign counter_out   = ctr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign params_valid  = pvalid_q;

endmodule

// File: tb/tb_param_loader.sv
// Scoreboard bench for param_loader: stimulus pushes expected load results, a monitor
// pops and compares them on every done/error pulse.
module tb_param_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         usk = 1'b0, usn = 1'b0, usc = 1'b0;
  logic [1:0]   chunk_type = 2'd0;
  logic         chunk_valid = 1'b0;
  logic [31:0]  chunk = 32'd0;
  logic [31:0]  trng_data = 32'd0;
  logic         trng_ready = 1'b0;
  logic         chunk_request, trng_request;
  logic [1:0]   request_type;
  logic [4:0]   chunk_index;
  logic [255:0] key_out;
  logic [95:0]  nonce_out;
  logic [31:0]  counter_out;
  logic         busy, done, error, params_valid;

  param_loader #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .use_streamed_key    (usk),
    .use_streamed_nonce  (usn),
    .use_streamed_counter(usc),
    .chunk_type          (chunk_type),
    .chunk_valid         (chunk_valid),
    .chunk               (chunk),
    .chunk_request       (chunk_request),
    .request_type        (request_type),
    .chunk_index         (chunk_index),
    .trng_data           (trng_data),
    .trng_ready          (trng_ready),
    .trng_request        (trng_request),
    .key_out             (key_out),
    .nonce_out           (nonce_out),
    .counter_out         (counter_out),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .params_valid        (params_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         is_err;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [255:0] KeyStream = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
  localparam logic [95:0]  NonceStream = 96'h0000000C_0000000B_0000000A;
  localparam logic [255:0] KeyTrng = 256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100;
  localparam logic [95:0]  NonceTrng = 96'h0000010A_00000109_00000108;

  // Responder controls
  logic stream_en = 1'b0;
  logic trng_en = 1'b0;
  int   mismatch_left = 0;
  int   trng_n = 0;
  int   trng_cyc = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] stream_word(input logic [1:0] t, input logic [4:0] idx);
    case (t)
      2'd0:    return 32'd1 + 32'(idx);
      2'd1:    return 32'hA + 32'(idx);
      default: return 32'h5;
    endcase
  endfunction

  function automatic exp_t good(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    exp_t e;
    e.is_err = 1'b0;
    e.key    = k;
    e.nonce  = n;
    e.ctr    = c;
    return e;
  endfunction

  // Chunk / TRNG responder, driven just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    chunk_valid = 1'b0;
    trng_ready  = 1'b0;
    if (chunk_request) begin
      if (request_type == 2'd1 && mismatch_left > 0) begin
        chunk_valid = 1'b1;
        chunk_type  = 2'd0;
        chunk       = 32'hDEADBEEF;
        mismatch_left--;
      end else if (stream_en) begin
        chunk_valid = 1'b1;
        chunk_type  = request_type;
        chunk       = stream_word(request_type, chunk_index);
      end
    end
    if (trng_en) begin
      trng_cyc++;
      if (trng_cyc % 3 == 0) begin
        trng_ready = 1'b1;
        trng_data  = 32'h100 + 32'(trng_n);
        if (trng_request) trng_n++;
      end
    end
  end

  // Monitor: compares each completion or abort against the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && (done || error)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got done=%0b error=%0b expected none", done, error);
      end else begin
        e = exp_q.pop_front();
        check("event_is_error", 256'(error), 256'(e.is_err));
        check("event_is_done", 256'(done), 256'(!e.is_err));
        check("params_valid", 256'(params_valid), 256'(!e.is_err));
        if (!e.is_err) begin
          check("key_out", key_out, e.key);
          check("nonce_out", 256'(nonce_out), 256'(e.nonce));
          check("counter_out", 256'(counter_out), 256'(e.ctr));
        end
      end
    end
    if (chunk_request || trng_request) begin
      check("req_exclusive", 256'(chunk_request & trng_request), 256'(0));
    end
  end

  task automatic do_start(input logic hold);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 if (!hold) start = 1'b0;
  endtask

  task automatic wait_event(input string name, input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(done || error) && cycles < limit);
    if (!(done || error)) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no done/error within %0d cycles expected one", name, limit);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_done"}, 256'(done), 256'(0));
    check({tag, "_error"}, 256'(error), 256'(0));
    check({tag, "_params_valid"}, 256'(params_valid), 256'(0));
    check({tag, "_chunk_request"}, 256'(chunk_request), 256'(0));
    check({tag, "_trng_request"}, 256'(trng_request), 256'(0));
    check({tag, "_request_type"}, 256'(request_type), 256'(0));
    check({tag, "_chunk_index"}, 256'(chunk_index), 256'(0));
    check({tag, "_key_out"}, key_out, 256'(0));
    check({tag, "_nonce_out"}, 256'(nonce_out), 256'(0));
    check({tag, "_counter_out"}, 256'(counter_out), 256'(0));
  endtask

  initial begin
    int cyc;
    int k;
    exp_t e;

    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All streamed, one word per cycle: done in the 14th cycle after the start edge
    {usk, usn, usc} = 3'b111;
    stream_en = 1'b1;
    exp_q.push_back(good(KeyStream, NonceStream, 32'h5));
    do_start(1'b0);
    wait_event("stream_done", 40, cyc);
    check("stream_done_latency", 256'(cyc), 256'(14));
    repeat (3) @(negedge clk);
    check("stream_idle_busy", 256'(busy), 256'(0));

    // All default sources, TRNG ready every third cycle
    {usk, usn, usc} = 3'b000;
    stream_en = 1'b0;
    trng_n = 0;
    trng_en = 1'b1;
    exp_q.push_back(good(KeyTrng, NonceTrng, 32'h0));
    do_start(1'b0);
    check("trng_busy_after_start", 256'(busy), 256'(1));
    wait_event("trng_done", 200, cyc);
    trng_en = 1'b0;
    repeat (3) @(negedge clk);

    // Streamed nonce with non-matching chunk_type first
    {usk, usn, usc} = 3'b111;
    stream_en = 1'b1;
    mismatch_left = 2;
    exp_q.push_back(good(KeyStream, NonceStream, 32'h5));
    do_start(1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(request_type == 2'd1 && chunk_request) && k < 40);
    check("mismatch_reached_nonce", 256'(request_type), 256'(1));
    check("mismatch_idx_c0", 256'(chunk_index), 256'(0));
    @(negedge clk);
    check("mismatch_idx_c1", 256'(chunk_index), 256'(0));
    @(negedge clk);
    check("mismatch_idx_c2", 256'(chunk_index), 256'(0));
    check("mismatch_no_error", 256'(error), 256'(0));
    @(negedge clk);
    check("mismatch_idx_after_match", 256'(chunk_index), 256'(1));
    wait_event("mismatch_done", 40, cyc);
    repeat (3) @(negedge clk);

    // Timeout with TRNG never ready: error in the 5th cycle of KEY
    {usk, usn, usc} = 3'b000;
    stream_en = 1'b0;
    e.is_err = 1'b1;
    e.key = '0;
    e.nonce = '0;
    e.ctr = '0;
    exp_q.push_back(e);
    do_start(1'b0);
    check("timeout_trng_request", 256'(trng_request), 256'(1));
    wait_event("timeout_error", 40, cyc);
    check("timeout_latency", 256'(cyc), 256'(5));
    check("timeout_trng_dropped", 256'(trng_request), 256'(0));
    @(negedge clk);
    check("timeout_error_pulse", 256'(error), 256'(0));
    check("timeout_busy_after", 256'(busy), 256'(0));
    check("timeout_pv_after", 256'(params_valid), 256'(0));
    repeat (3) @(negedge clk);

    // Reset mid-NONCE, then a clean load
    {usk, usn, usc} = 3'b111;
    stream_en = 1'b1;
    exp_q.push_back(good(KeyStream, NonceStream, 32'h5));
    do_start(1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (request_type != 2'd1 && k < 40);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_stays_idle", 256'(busy), 256'(0));
    exp_q.push_back(good(KeyStream, NonceStream, 32'h5));
    do_start(1'b0);
    wait_event("postreset_done", 40, cyc);
    check("postreset_latency", 256'(cyc), 256'(14));
    repeat (3) @(negedge clk);

    // start held high: one load, one done, then a fresh load
    exp_q.push_back(good(KeyStream, NonceStream, 32'h5));
    exp_q.push_back(good(KeyStream, NonceStream, 32'h5));
    do_start(1'b1);
    wait_event("held_first_done", 40, cyc);
    check("held_first_latency", 256'(cyc), 256'(14));
    check("held_busy_at_done", 256'(busy), 256'(0));
    @(negedge clk);
    check("held_done_one_cycle", 256'(done), 256'(0));
    check("held_second_busy", 256'(busy), 256'(1));
    check("held_second_pv_cleared", 256'(params_valid), 256'(0));
    start = 1'b0;
    wait_event("held_second_done", 40, cyc);
    check("held_second_latency", 256'(cyc), 256'(13));
    repeat (4) @(negedge clk);
    check("held_no_third_load", 256'(busy), 256'(0));

    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
